// File: rtl/cmd_router_if.sv
// Signal bundle between cmd_router and its host; modport slave is the router side.
// uart_next is present only when CMD_ROUTER_CYCLE_EN is defined.
interface cmd_router_if #(
  parameter int NUM_MODES = 4,
  parameter int NUM_BTN   = 4,
  parameter int NUM_SUB   = 2
);
  localparam int MW = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1;

  logic [NUM_MODES-1:0]         sw;
  logic [NUM_SUB-1:0]           sw_sub;
  logic [NUM_BTN-1:0]           btn_edge;
  logic [NUM_BTN-1:0]           uart_btn;
  logic [NUM_MODES-1:0]         uart_mode;
  logic [NUM_SUB-1:0]           uart_sub_tgl;
  logic                         uart_rst;
`ifdef CMD_ROUTER_CYCLE_EN
  logic                         uart_next;
`endif
  logic [NUM_MODES*NUM_BTN-1:0] c_btn;
  logic [NUM_SUB-1:0]           c_sub;
  logic [MW-1:0]                mode;
  logic                         mode_chg;
  logic                         guard_busy;

`ifdef CMD_ROUTER_CYCLE_EN
  modport master (
    output sw, sw_sub, btn_edge, uart_btn, uart_mode, uart_sub_tgl, uart_rst, uart_next,
    input  c_btn, c_sub, mode, mode_chg, guard_busy
  );
  modport slave (
    input  sw, sw_sub, btn_edge, uart_btn, uart_mode, uart_sub_tgl, uart_rst, uart_next,
    output c_btn, c_sub, mode, mode_chg, guard_busy
  );
`else
  modport master (
    output sw, sw_sub, btn_edge, uart_btn, uart_mode, uart_sub_tgl, uart_rst,
    input  c_btn, c_sub, mode, mode_chg, guard_busy
  );
  modport slave (
    input  sw, sw_sub, btn_edge, uart_btn, uart_mode, uart_sub_tgl, uart_rst,
    output c_btn, c_sub, mode, mode_chg, guard_busy
  );
`endif
endinterface

// File: rtl/cmd_router.sv
// Mode/sub-flag command router: synchronises switches, merges UART requests, blanks buttons after a mode change.
// Optional CMD_ROUTER_CYCLE_EN adds the uart_next mode-advance input.
module cmd_router #(
  parameter int NUM_MODES = 4,
  parameter int NUM_BTN   = 4,
  parameter int NUM_SUB   = 2,
  parameter int GUARD_CYC = 16
) (
  input logic        clk,
  input logic        rst,
  cmd_router_if.slave bus
);
  localparam int MW = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1;
  localparam int GW = (GUARD_CYC > 0) ? $clog2(GUARD_CYC + 1) : 1;
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYC);

  logic [NUM_MODES-1:0]         r_sw_p0, r_sw_p1, r_sw_prev;
  logic [NUM_SUB-1:0]           r_sub_p0, r_sub_p1, r_sub_prev;
  logic [1:0]                   r_warm;
  logic [MW-1:0]                r_mode;
  logic                         r_mode_chg;
  logic [GW-1:0]                r_guard;
  logic [NUM_SUB-1:0]           r_c_sub;

  logic                         w_edge_en;
  logic [NUM_MODES-1:0]         w_sw_rise;
  logic [NUM_SUB-1:0]           w_sub_rise, w_sub_fall;
  logic [NUM_MODES-1:0]         w_req;
  logic                         w_req_any;
  logic [MW-1:0]                w_req_idx;
  logic                         w_guard_busy;
  logic [NUM_BTN-1:0]           w_btn;
  logic [NUM_MODES*NUM_BTN-1:0] w_c_btn;

  // Stage p0/p1: two-flop synchronisers, then previous-value flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_p0    <= '0;
      r_sw_p1    <= '0;
      r_sw_prev  <= '0;
      r_sub_p0   <= '0;
      r_sub_p1   <= '0;
      r_sub_prev <= '0;
      r_warm     <= 2'd3;
    end else begin
      r_sw_p0    <= bus.sw;
      r_sw_p1    <= r_sw_p0;
      r_sw_prev  <= r_sw_p1;
      r_sub_p0   <= bus.sw_sub;
      r_sub_p1   <= r_sub_p0;
      r_sub_prev <= r_sub_p1;
      if (r_warm != 2'd0) r_warm <= r_warm - 2'd1;
    end
  end

  // Warm-up hides the fake edges of switches already high when reset releases
  assign w_edge_en  = (r_warm == 2'd0);
  assign w_sw_rise  = r_sw_p1 & ~r_sw_prev & {NUM_MODES{w_edge_en}};
  assign w_sub_rise = r_sub_p1 & ~r_sub_prev & {NUM_SUB{w_edge_en}};
  assign w_sub_fall = ~r_sub_p1 & r_sub_prev & {NUM_SUB{w_edge_en}};

  assign w_req     = bus.uart_mode | w_sw_rise;
  assign w_req_any = |w_req;

  // Descending scan so the lowest requesting index is the final assignment
  always_comb begin
    w_req_idx = '0;
    for (int i = NUM_MODES - 1; i >= 0; i--) begin
      if (w_req[i]) w_req_idx = MW'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode     <= '0;
      r_mode_chg <= 1'b0;
      r_guard    <= '0;
      r_c_sub    <= '0;
    end else if (bus.uart_rst) begin
      r_mode     <= '0;
      r_mode_chg <= 1'b0;
      r_guard    <= '0;
      r_c_sub    <= '0;
    end else begin
      r_mode_chg <= 1'b0;
      if (r_guard != '0) r_guard <= r_guard - GW'(1);
      if (w_req_any) begin
        if (w_req_idx != r_mode) begin
          r_mode     <= w_req_idx;
          r_mode_chg <= 1'b1;
          r_guard    <= GUARD_LOAD;
        end
      end
`ifdef CMD_ROUTER_CYCLE_EN
      else if (bus.uart_next) begin
        r_mode     <= (r_mode == MW'(NUM_MODES - 1)) ? '0 : r_mode + MW'(1);
        r_mode_chg <= 1'b1;
        r_guard    <= GUARD_LOAD;
      end
`endif
      for (int j = 0; j < NUM_SUB; j++) begin
        if (bus.uart_sub_tgl[j])  r_c_sub[j] <= ~r_c_sub[j];
        else if (w_sub_rise[j])   r_c_sub[j] <= 1'b1;
        else if (w_sub_fall[j])   r_c_sub[j] <= 1'b0;
      end
    end
  end

  assign w_guard_busy = (r_guard != '0);
  assign w_btn        = bus.btn_edge | bus.uart_btn;

  always_comb begin
    w_c_btn = '0;
    for (int m = 0; m < NUM_MODES; m++) begin
      for (int b = 0; b < NUM_BTN; b++) begin
        w_c_btn[m*NUM_BTN+b] = w_btn[b] & (r_mode == MW'(m)) & ~w_guard_busy;
      end
    end
  end

  assign bus.c_btn      = w_c_btn;
  assign bus.c_sub      = r_c_sub;
  assign bus.mode       = r_mode;
  assign bus.mode_chg   = r_mode_chg;
  assign bus.guard_busy = w_guard_busy;
endmodule

// File: tb/tb_cmd_router.sv
// Directed bench for cmd_router at default parameters: vector table plus multi-cycle sequences.
module tb_cmd_router;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cmd_router_if #(.NUM_MODES(4), .NUM_BTN(4), .NUM_SUB(2)) bus();

  cmd_router #(.NUM_MODES(4), .NUM_BTN(4), .NUM_SUB(2), .GUARD_CYC(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          pre;
    logic [3:0]  umode;
    logic [3:0]  ubtn;
    logic [3:0]  bedge;
    logic        urst;
    logic [1:0]  tgl;
    logic [15:0] cbtn;
    logic [1:0]  mode;
    logic        chg;
    logic        busy;
    logic [1:0]  csub;
  } vec_t;

  vec_t tv [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    bus.uart_mode    = '0;
    bus.uart_btn     = '0;
    bus.btn_edge     = '0;
    bus.uart_rst     = 1'b0;
    bus.uart_sub_tgl = '0;
`ifdef CMD_ROUTER_CYCLE_EN
    bus.uart_next    = 1'b0;
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    // pre umode   ubtn    bedge   urst  tgl    cbtn      mode  chg  busy csub
    tv[0]  = '{0,  4'b0000, 4'b0001, 4'b0000, 1'b0, 2'b00, 16'h0001, 2'd0, 1'b0, 1'b0, 2'b00};
    tv[1]  = '{0,  4'b0000, 4'b0000, 4'b1000, 1'b0, 2'b00, 16'h0008, 2'd0, 1'b0, 1'b0, 2'b00};
    tv[2]  = '{0,  4'b0100, 4'b0000, 4'b0000, 1'b0, 2'b00, 16'h0000, 2'd2, 1'b1, 1'b1, 2'b00};
    tv[3]  = '{0,  4'b0000, 4'b0000, 4'b0001, 1'b0, 2'b00, 16'h0000, 2'd2, 1'b0, 1'b1, 2'b00};
    tv[4]  = '{13, 4'b0000, 4'b0010, 4'b0000, 1'b0, 2'b00, 16'h0000, 2'd2, 1'b0, 1'b1, 2'b00};
    tv[5]  = '{0,  4'b0000, 4'b0000, 4'b0001, 1'b0, 2'b00, 16'h0000, 2'd2, 1'b0, 1'b0, 2'b00};
    tv[6]  = '{0,  4'b0000, 4'b0000, 4'b0001, 1'b0, 2'b00, 16'h0100, 2'd2, 1'b0, 1'b0, 2'b00};
    tv[7]  = '{0,  4'b0110, 4'b0000, 4'b0000, 1'b0, 2'b00, 16'h0000, 2'd1, 1'b1, 1'b1, 2'b00};
    tv[8]  = '{16, 4'b0010, 4'b0000, 4'b0000, 1'b0, 2'b00, 16'h0000, 2'd1, 1'b0, 1'b0, 2'b00};
    tv[9]  = '{0,  4'b0000, 4'b1111, 4'b0000, 1'b0, 2'b00, 16'h00F0, 2'd1, 1'b0, 1'b0, 2'b00};
    tv[10] = '{0,  4'b1000, 4'b0000, 4'b0000, 1'b0, 2'b00, 16'h0000, 2'd3, 1'b1, 1'b1, 2'b00};
    tv[11] = '{5,  4'b0001, 4'b0000, 4'b0000, 1'b0, 2'b00, 16'h0000, 2'd0, 1'b1, 1'b1, 2'b00};
    tv[12] = '{14, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'b00, 16'h0000, 2'd0, 1'b0, 1'b1, 2'b00};
    tv[13] = '{0,  4'b0000, 4'b0001, 4'b0000, 1'b0, 2'b00, 16'h0000, 2'd0, 1'b0, 1'b0, 2'b00};
    tv[14] = '{0,  4'b0000, 4'b0000, 4'b0000, 1'b0, 2'b01, 16'h0000, 2'd0, 1'b0, 1'b0, 2'b01};
    tv[15] = '{0,  4'b0000, 4'b0000, 4'b0000, 1'b0, 2'b11, 16'h0000, 2'd0, 1'b0, 1'b0, 2'b10};
    tv[16] = '{0,  4'b0100, 4'b0000, 4'b0000, 1'b0, 2'b00, 16'h0000, 2'd2, 1'b1, 1'b1, 2'b10};
    tv[17] = '{0,  4'b1000, 4'b0000, 4'b0000, 1'b1, 2'b01, 16'h0000, 2'd0, 1'b0, 1'b0, 2'b00};
    tv[18] = '{0,  4'b0000, 4'b0001, 4'b0000, 1'b0, 2'b00, 16'h0001, 2'd0, 1'b0, 1'b0, 2'b00};

    // Reset with sw_sub[0] held high throughout
    rst        = 1'b1;
    bus.sw     = '0;
    bus.sw_sub = 2'b01;
    clear_pulses();
    repeat (3) @(posedge clk);
    #1;
    chk("rst mode", 32'(bus.mode), 32'd0);
    chk("rst mode_chg", 32'(bus.mode_chg), 32'd0);
    chk("rst guard_busy", 32'(bus.guard_busy), 32'd0);
    chk("rst c_sub", 32'(bus.c_sub), 32'd0);
    chk("rst c_btn", 32'(bus.c_btn), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("warmup%0d c_sub", k), 32'(bus.c_sub), 32'd0);
    end
    chk("warmup mode", 32'(bus.mode), 32'd0);

    // Vector table
    for (int i = 0; i < 19; i++) begin
      clear_pulses();
      for (int p = 0; p < tv[i].pre; p++) tick();
      bus.uart_mode    = tv[i].umode;
      bus.uart_btn     = tv[i].ubtn;
      bus.btn_edge     = tv[i].bedge;
      bus.uart_rst     = tv[i].urst;
      bus.uart_sub_tgl = tv[i].tgl;
      #2;
      chk($sformatf("row%0d c_btn", i), 32'(bus.c_btn), 32'(tv[i].cbtn));
      tick();
      clear_pulses();
      chk($sformatf("row%0d mode", i), 32'(bus.mode), 32'(tv[i].mode));
      chk($sformatf("row%0d mode_chg", i), 32'(bus.mode_chg), 32'(tv[i].chg));
      chk($sformatf("row%0d guard_busy", i), 32'(bus.guard_busy), 32'(tv[i].busy));
      chk($sformatf("row%0d c_sub", i), 32'(bus.c_sub), 32'(tv[i].csub));
    end

    // sw_sub[0] falls after a toggle set it; sw_sub[1] rises
    bus.uart_sub_tgl = 2'b01;
    tick();
    clear_pulses();
    chk("subtgl c_sub", 32'(bus.c_sub), 32'b01);
    bus.sw_sub = 2'b00;
    tick();
    chk("subfall e1", 32'(bus.c_sub), 32'b01);
    tick();
    chk("subfall e2", 32'(bus.c_sub), 32'b01);
    tick();
    chk("subfall e3", 32'(bus.c_sub), 32'b00);
    bus.sw_sub = 2'b10;
    tick();
    tick();
    chk("subrise e2", 32'(bus.c_sub), 32'b00);
    tick();
    chk("subrise e3", 32'(bus.c_sub), 32'b10);

    // sw=1010 raised together: lowest index wins three edges later
    bus.sw = 4'b1010;
    tick();
    chk("sw e1 mode", 32'(bus.mode), 32'd0);
    tick();
    chk("sw e2 mode", 32'(bus.mode), 32'd0);
    tick();
    chk("sw e3 mode", 32'(bus.mode), 32'd1);
    chk("sw e3 mode_chg", 32'(bus.mode_chg), 32'd1);
    tick();
    chk("sw e4 mode_chg", 32'(bus.mode_chg), 32'd0);
    repeat (20) tick();
    bus.sw = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("swfall%0d mode", k), 32'(bus.mode), 32'd1);
      chk($sformatf("swfall%0d mode_chg", k), 32'(bus.mode_chg), 32'd0);
    end
    bus.sw = 4'b0000;
    repeat (4) tick();

`ifdef CMD_ROUTER_CYCLE_EN
    bus.uart_mode = 4'b1000;
    tick();
    clear_pulses();
    chk("cyc set3 mode", 32'(bus.mode), 32'd3);
    tick();
    bus.uart_next = 1'b1;
    tick();
    clear_pulses();
    chk("cyc wrap mode", 32'(bus.mode), 32'd0);
    chk("cyc wrap mode_chg", 32'(bus.mode_chg), 32'd1);
    chk("cyc wrap guard_busy", 32'(bus.guard_busy), 32'd1);
    tick();
    bus.uart_next = 1'b1;
    bus.uart_mode = 4'b0100;
    tick();
    clear_pulses();
    chk("cyc prio mode", 32'(bus.mode), 32'd2);
    tick();
`endif

    // Asynchronous reset takes effect without a clock edge
    #3;
    rst = 1'b1;
    #1;
    chk("async rst mode", 32'(bus.mode), 32'd0);
    chk("async rst c_sub", 32'(bus.c_sub), 32'd0);
    chk("async rst guard_busy", 32'(bus.guard_busy), 32'd0);
    tick();
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
